mem_loader: RTL and testbench

Program loader that fills memory from an external byte stream while holding the core in reset. It writes `LOAD_LEN` bytes starting at `LOAD_BASE` through the same port the fetcher uses (`addr`/`din`/`we`/`dout`). It then reads the range back and checks it with a checksum. On a match it releases the core's `reset_n` and pulses `trigger_program`.

---
 rtl/mem_loader.sv | 172 +++++++++++++++++
 tb/tb_mem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: streams LOAD_LEN bytes into memory at LOAD_BASE while the core
// is held in reset, optionally reads the range back and compares checksums,
// then releases the core and pulses trigger_program once.
module mem_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 16'h0200,
  parameter int                    LOAD_LEN   = 256,
  parameter bit                    VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [REG_WIDTH-1:0]  s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  core_reset_n,
  output logic                  trigger_program,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Counters are one bit wider than the address so LOAD_LEN = 2^ADDR_WIDTH fits.
  localparam int                  CW       = ADDR_WIDTH + 1;
  localparam int                  LAST_INT = LOAD_LEN - 1;
  localparam logic [CW-1:0]       LAST_IDX = LAST_INT[CW-1:0];
  localparam logic [CW-1:0]       CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        wcnt_r;
  logic [CW-1:0]        rcnt_r;
  logic [REG_WIDTH-1:0] wsum_r;
  logic [REG_WIDTH-1:0] vsum_r;
  logic                 xfer_s;
  logic [REG_WIDTH-1:0] final_sum_s;

  logic s_ready_r, core_reset_n_r, trigger_r, busy_r, done_r, error_r;

  assign xfer_s      = (state_r == ST_LOAD) && s_valid;
  // The last readback byte arrives in CHECK, so fold it in before comparing.
  assign final_sum_s = vsum_r + mem_dout;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE, DONE and ERROR.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: begin
        if (xfer_s && (wcnt_r == LAST_IDX)) begin
          if (VERIFY) state_s = ST_VERIFY; else state_s = ST_RELEASE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_VERIFY:  if (rcnt_r == LAST_IDX) state_s = ST_CHECK; else state_s = ST_VERIFY;
      ST_CHECK:   if (final_sum_s == wsum_r) state_s = ST_RELEASE; else state_s = ST_ERROR;
      ST_RELEASE: state_s = ST_RUN;
      ST_RUN:     state_s = ST_DONE;
      ST_DONE:    if (start) state_s = ST_LOAD; else state_s = ST_DONE;
      ST_ERROR:   if (start) state_s = ST_LOAD; else state_s = ST_ERROR;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Write/read counters and running checksums; cleared when a session starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_r <= {CW{1'b0}};
      rcnt_r <= {CW{1'b0}};
      wsum_r <= {REG_WIDTH{1'b0}};
      vsum_r <= {REG_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            wcnt_r <= {CW{1'b0}};
            rcnt_r <= {CW{1'b0}};
            wsum_r <= {REG_WIDTH{1'b0}};
            vsum_r <= {REG_WIDTH{1'b0}};
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            wcnt_r <= wcnt_r + CNT_ONE;
            wsum_r <= wsum_r + s_data;
          end
        end
        ST_VERIFY: begin
          rcnt_r <= rcnt_r + CNT_ONE;
          // Read data lags the address by one cycle, so skip the first cycle.
          if (rcnt_r != {CW{1'b0}}) begin
            vsum_r <= vsum_r + mem_dout;
          end
        end
        default: begin
          wcnt_r <= wcnt_r;
        end
      endcase
    end
  end

  // Status outputs are registered copies of the decode of the next state,
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_r      <= 1'b0;
      core_reset_n_r <= 1'b0;
      trigger_r      <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      s_ready_r      <= (state_s == ST_LOAD);
      core_reset_n_r <= (state_s == ST_RELEASE) || (state_s == ST_RUN) || (state_s == ST_DONE);
      trigger_r      <= (state_s == ST_RUN);
      busy_r         <= (state_s == ST_LOAD) || (state_s == ST_VERIFY);
      done_r         <= (state_s == ST_DONE);
      error_r        <= (state_s == ST_ERROR);
    end
  end

  assign s_ready         = s_ready_r;
  assign core_reset_n    = core_reset_n_r;
  assign trigger_program = trigger_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign error           = error_r;

  // Memory port: writes follow the stream combinationally during LOAD,
  // readback addresses walk the same range during VERIFY.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {ADDR_WIDTH{1'b0}};
    mem_din  = {REG_WIDTH{1'b0}};
    if (state_r == ST_LOAD) begin
      mem_we   = s_valid;
      mem_addr = LOAD_BASE + wcnt_r[ADDR_WIDTH-1:0];
      mem_din  = s_data;
    end else if (state_r == ST_VERIFY) begin
      mem_addr = LOAD_BASE + rcnt_r[ADDR_WIDTH-1:0];
    end else begin
      mem_addr = {ADDR_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: two instances (base 0x0200 and wrapping base 0xFFFE,
// both LOAD_LEN=4) share one stimulus stream; each has its own memory model.
// Expected memory accesses are queued when a session is issued and checked
// by a negedge monitor whenever the DUT writes or reads back.
module tb_mem_loader;
  localparam int          L     = 4;
  localparam logic [15:0] BASE0 = 16'h0200;
  localparam logic [15:0] BASE1 = 16'hFFFE;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, corrupt;
  logic [7:0]  s_data;
  logic [1:0]  s_ready_v, mem_we_v, crn_v, trig_v, busy_v, done_v, err_v;
  logic [15:0] addr_v [2];
  logic [7:0]  din_v  [2];
  logic [7:0]  dout_v [2];
  logic [7:0]  mem0 [65536];
  logic [7:0]  mem1 [65536];

  acc_t q0[$];
  acc_t q1[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   rise_cyc [2];
  int   trig_cnt [2];
  int   trig_cyc [2];
  logic [1:0] crn_prev = 2'b00;

  always #5 clk = ~clk;

  // Edge counter: value k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  mem_loader #(.ADDR_WIDTH(16), .REG_WIDTH(8), .LOAD_BASE(BASE0), .LOAD_LEN(L), .VERIFY(1'b1)) u_main (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_v[0]), .mem_addr(addr_v[0]), .mem_din(din_v[0]), .mem_we(mem_we_v[0]),
    .mem_dout(dout_v[0]), .core_reset_n(crn_v[0]), .trigger_program(trig_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]));

  mem_loader #(.ADDR_WIDTH(16), .REG_WIDTH(8), .LOAD_BASE(BASE1), .LOAD_LEN(L), .VERIFY(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_v[1]), .mem_addr(addr_v[1]), .mem_din(din_v[1]), .mem_we(mem_we_v[1]),
    .mem_dout(dout_v[1]), .core_reset_n(crn_v[1]), .trigger_program(trig_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]));

  // Synchronous-read memory models; corrupt makes byte base+1 read back as 0x04.
  always @(posedge clk) begin
    if (mem_we_v[0]) mem0[addr_v[0]] <= din_v[0];
    if (mem_we_v[1]) mem1[addr_v[1]] <= din_v[1];
    dout_v[0] <= (corrupt && addr_v[0] == BASE0 + 16'd1) ? 8'h04 : mem0[addr_v[0]];
    dout_v[1] <= (corrupt && addr_v[1] == BASE1 + 16'd1) ? 8'h04 : mem1[addr_v[1]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every memory access against the queue; track release/trigger.
  always @(negedge clk) begin
    acc_t got, e;
    for (int g = 0; g < 2; g++) begin
      if (!reset && (mem_we_v[g] || (busy_v[g] && !s_ready_v[g]))) begin
        got = {mem_we_v[g], addr_v[g], (mem_we_v[g] ? din_v[g] : 8'h00)};
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_access[%0d]", g), 32'(got), 32'hFFFF_FFFF);
        end else begin
          if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("mem_access[%0d]", g), 32'(got), 32'(e));
        end
      end
      if (crn_v[g] && !crn_prev[g]) rise_cyc[g] = cyc;
      crn_prev[g] = crn_v[g];
      if (trig_v[g]) begin
        trig_cnt[g]++;
        trig_cyc[g] = cyc;
      end
    end
  end

  // Issue one 4-byte session. t0 is the edge that samples start (spec edge 1,
  // the first LOAD cycle follows it). gap stalls s_valid after the 2nd byte;
  // poke raises start during LOAD, which must be ignored.
  task automatic run_session(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int gap, input bit poke, output int t0);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, BASE0 + 16'(i), bs[i]});
      q1.push_back({1'b1, BASE1 + 16'(i), bs[i]});
    end
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b0, BASE0 + 16'(i), 8'h00});
      q1.push_back({1'b0, BASE1 + 16'(i), 8'h00});
    end
    for (int g = 0; g < 2; g++) begin
      rise_cyc[g] = -1; trig_cnt[g] = 0; trig_cyc[g] = -1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = bs[i];
      if (poke && i == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 1 && gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
      end
    end
    s_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done_v == 2'b11 || err_v == 2'b11) break;
      @(posedge clk); #1;
    end
    chk("session_end_reached", 32'(done_v == 2'b11 || err_v == 2'b11), 32'd1);
    @(posedge clk); #1;
    chk("access_queue_drained", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Checks for a session that must end in DONE. Spec edge 2L+2 (=10) is t0+2L+1.
  task automatic expect_ok(input string tag, input int t0, input int gap);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_release_edge[%0d]", tag, g), 32'(rise_cyc[g]), 32'(t0 + 2*L + 1 + gap));
      chk($sformatf("%s_trigger_count[%0d]", tag, g), 32'(trig_cnt[g]), 32'd1);
      chk($sformatf("%s_trigger_cycle[%0d]", tag, g), 32'(trig_cyc[g]), 32'(t0 + 2*L + 2 + gap));
      chk($sformatf("%s_done_err_crn_busy[%0d]", tag, g),
          {28'd0, done_v[g], err_v[g], crn_v[g], busy_v[g]}, 32'b1010);
    end
  endtask

  task automatic expect_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_flags[%0d]", tag, g),
          {25'd0, s_ready_v[g], mem_we_v[g], crn_v[g], trig_v[g], busy_v[g], done_v[g], err_v[g]}, 32'd0);
      chk($sformatf("%s_addr_din[%0d]", tag, g), {8'd0, addr_v[g], din_v[g]}, 32'd0);
    end
  endtask

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; corrupt = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rise_cyc[g] = -1; trig_cnt[g] = 0; trig_cyc[g] = -1;
    end

    // Reset for two cycles, then core stays held until start.
    repeat (2) begin @(posedge clk); #1; end
    expect_reset_outputs("reset");
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    expect_reset_outputs("idle_after_reset");

    // Back-to-back load, verify, release.
    run_session(8'hA9, 8'h05, 8'h69, 8'h03, 0, 1'b0, t0);
    expect_ok("basic", t0, 0);

    // Backpressure: 3 stall cycles between bytes 2 and 3, plus an ignored start.
    run_session(8'hA9, 8'h05, 8'h69, 8'h03, 3, 1'b1, t0);
    expect_ok("stall", t0, 3);

    // Corrupted readback at base+1.
    corrupt = 1'b1;
    run_session(8'hA9, 8'h05, 8'h69, 8'h03, 0, 1'b0, t0);
    corrupt = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("corrupt_err_done_crn[%0d]", g), {29'd0, err_v[g], done_v[g], crn_v[g]}, 32'b100);
      chk($sformatf("corrupt_no_release[%0d]", g), 32'(rise_cyc[g]), 32'hFFFF_FFFF);
      chk($sformatf("corrupt_no_trigger[%0d]", g), 32'(trig_cnt[g]), 32'd0);
    end

    // A fresh start from ERROR reloads cleanly.
    run_session(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0, t0);
    expect_ok("reload", t0, 0);

    // Mid-session reset after two bytes (with an ignored start in LOAD).
    q0.push_back({1'b1, BASE0, 8'hA9}); q0.push_back({1'b1, BASE0 + 16'd1, 8'h05});
    q1.push_back({1'b1, BASE1, 8'hA9}); q1.push_back({1'b1, BASE1 + 16'd1, 8'h05});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA9;
    @(posedge clk); #1;
    s_data = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    expect_reset_outputs("mid_reset");
    reset = 1'b0;
    chk("mid_reset_two_writes", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk); #1;
    chk("mid_reset_core_held", {30'd0, crn_v}, 32'd0);

    run_session(8'h5A, 8'hC3, 8'h0F, 8'hF0, 0, 1'b0, t0);
    expect_ok("after_reset", t0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
